// File: rtl/io_uart_tx.sv
// io_uart_tx -- write-only UART transmitter on the CPU's shared 8-bit I/O bus.
//
// An OUT to PORT_DATA queues one byte in a small FIFO. A serialiser drains the
// FIFO and sends each byte as 8N1 (start, 8 data bits LSB first, stop) on tx.
// Consecutive frames are sent with no idle gap. An IN from PORT_STATUS returns
// {4'b0, overflow, tx_busy, fifo_empty, fifo_full}. Reading the status clears
// the sticky overflow flag when the read strobe ends.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   addr_bus   I/O port address
//   mem_io     high = I/O cycle; memory cycles are ignored
//   io_wr      write strobe (CPU drives bus)
//   io_rd      read strobe (block may drive bus)
//   bus        shared data bus, driven only during a status read
//   tx         serial output, idle high
//   irq_empty  high while the FIFO is empty and the transmitter is idle

module io_uart_tx #(
   parameter logic [7:0]  PORT_DATA    = 8'h00,
   parameter logic [7:0]  PORT_STATUS  = 8'h01,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] addr_bus,
   input  logic       mem_io,
   input  logic       io_wr,
   input  logic       io_rd,
   inout  logic [7:0] bus,
   output logic       tx,
   output logic       irq_empty
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [7:0]  BIT_LOAD = 8'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t           state_q, state_d;
   logic             tx_q, tx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       bit_cnt_q, bit_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             wr_hit_q, wr_hit_d;
   logic             rd_hit_q, rd_hit_d;

   logic [7:0]       fifo_mem [FIFO_DEPTH];

   logic             wr_hit, rd_hit;
   logic             push, push_ok, pop, ovf_set, rd_fall;
   logic             fifo_empty, fifo_full, tx_busy;
   logic [7:0]       status;

   // ---------------------------------------------------------------- decode
   assign wr_hit   = mem_io & io_wr & (addr_bus == PORT_DATA);
   assign rd_hit   = mem_io & io_rd & (addr_bus == PORT_STATUS);
   assign wr_hit_d = wr_hit;
   assign rd_hit_d = rd_hit;

   // A held write strobe pushes only on its first cycle.
   assign push    = wr_hit & ~wr_hit_q;
   assign rd_fall = rd_hit_q & ~rd_hit;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_FULL);
   assign tx_busy    = (state_q != S_IDLE);

   assign status    = {4'b0000, ovf_q, tx_busy, fifo_empty, fifo_full};
   assign bus       = rd_hit ? status : 'z;
   assign tx        = tx_q;
   assign irq_empty = fifo_empty & ~tx_busy;

   // ------------------------------------------------------------ serialiser
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      bit_idx_d = bit_idx_q;
      pop       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               shift_d   = fifo_mem[rd_ptr_q];
               bit_cnt_d = BIT_LOAD;
               state_d   = S_START;
            end
         end
         S_START: begin
            if (bit_cnt_q == '0) begin
               bit_cnt_d = BIT_LOAD;
               bit_idx_d = '0;
               state_d   = S_DATA;
            end else begin
               bit_cnt_d = bit_cnt_q - 8'd1;
            end
         end
         S_DATA: begin
            if (bit_cnt_q == '0) begin
               bit_cnt_d = BIT_LOAD;
               shift_d   = shift_q >> 1;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q - 8'd1;
            end
         end
         S_STOP: begin
            if (bit_cnt_q == '0) begin
               // Back-to-back frames: pop straight into the next start bit.
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  shift_d   = fifo_mem[rd_ptr_q];
                  bit_cnt_d = BIT_LOAD;
                  state_d   = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               bit_cnt_d = bit_cnt_q - 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // tx is derived from the next state so it toggles on the state-change edge.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------ FIFO
   // A push into a full FIFO is still accepted when a pop frees a slot on
   // the same edge.
   assign push_ok = push & (~fifo_full | pop);
   assign ovf_set = push & fifo_full & ~pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;

      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({push_ok, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // A new overflow wins over a clear landing on the same edge.
      if (rd_fall) ovf_d = 1'b0;
      if (ovf_set) ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         tx_q      <= 1'b1;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         bit_idx_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         wr_hit_q  <= 1'b0;
         rd_hit_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         tx_q      <= tx_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         bit_idx_q <= bit_idx_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         wr_hit_q  <= wr_hit_d;
         rd_hit_q  <= rd_hit_d;
      end
   end

   // Storage needs no reset; the pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (!reset && push_ok) fifo_mem[wr_ptr_q] <= bus;
   end

endmodule

// File: tb/tb_io_uart_tx.sv
// Testbench for io_uart_tx. A frame-timing model (queue of bytes, cycle offset
// into the current 10-bit frame) predicts tx, irq_empty and the bus every
// cycle; directed sections add hand-computed literal expectations.

module tb_io_uart_tx;

   localparam int         C  = 4;
   localparam int         D  = 4;
   localparam int         FL = 10 * C;
   localparam logic [7:0] PD = 8'h00;
   localparam logic [7:0] PS = 8'h01;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] addr_bus = 8'h00;
   logic       mem_io = 1'b0;
   logic       io_wr = 1'b0;
   logic       io_rd = 1'b0;
   logic [7:0] bus_drv = 8'h00;
   logic       bus_oe = 1'b0;
   wire  [7:0] bus;
   logic       tx;
   logic       irq_empty;

   // Undriven bus reads as 8'hFF through the pull-ups.
   assign bus = bus_oe ? bus_drv : 8'bzzzzzzzz;
   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup pu_bus (bus[g]);
   end

   io_uart_tx #(
      .PORT_DATA   (PD),
      .PORT_STATUS (PS),
      .CLKS_PER_BIT(C),
      .FIFO_DEPTH  (D)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .addr_bus (addr_bus),
      .mem_io   (mem_io),
      .io_wr    (io_wr),
      .io_rd    (io_rd),
      .bus      (bus),
      .tx       (tx),
      .irq_empty(irq_empty)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------- model
   logic tb_wr_hit, tb_rd_hit;
   assign tb_wr_hit = mem_io & io_wr & (addr_bus == PD);
   assign tb_rd_hit = mem_io & io_rd & (addr_bus == PS);

   logic [7:0] mq[$];
   logic       m_ovf = 1'b0;
   logic       m_busy = 1'b0;
   logic       m_wr_prev = 1'b0;
   logic       m_rd_prev = 1'b0;
   logic       m_tx = 1'b1;
   logic [7:0] m_byte = 8'h00;
   int         m_t = 0;
   int         m_frames = 0;

   // Frame slot 0 is the start bit, 1..8 the data LSB first, 9 the stop bit.
   function automatic logic frame_bit(logic [7:0] b, int idx);
      if (idx == 0) return 1'b0;
      if (idx >= 9) return 1'b1;
      return b[idx-1];
   endfunction

   function automatic logic [7:0] m_status();
      return {4'b0000, m_ovf, m_busy, (mq.size() == 0), (mq.size() == D)};
   endfunction

   initial begin : model
      logic pop, full;
      forever begin
         @(posedge clk);
         if (reset) begin
            mq.delete();
            m_ovf = 1'b0; m_busy = 1'b0; m_t = 0;
            m_wr_prev = 1'b0; m_rd_prev = 1'b0; m_tx = 1'b1;
         end else begin
            full = (mq.size() == D);
            pop  = 1'b0;
            if (m_busy) begin
               if (m_t == FL - 1) m_busy = 1'b0;
               else m_t++;
            end
            if (!m_busy && mq.size() != 0) begin
               m_byte = mq.pop_front();
               m_busy = 1'b1;
               m_t    = 0;
               m_frames++;
               pop    = 1'b1;
            end
            if (m_rd_prev && !tb_rd_hit) m_ovf = 1'b0;
            if (tb_wr_hit && !m_wr_prev) begin
               if (full && !pop) m_ovf = 1'b1;
               else mq.push_back(bus_drv);
            end
            m_wr_prev = tb_wr_hit;
            m_rd_prev = tb_rd_hit;
            m_tx = m_busy ? frame_bit(m_byte, m_t / C) : 1'b1;
         end
      end
   end

   initial begin : compare
      forever begin
         @(posedge clk);
         #1;
         chk("tx", {7'b0, tx}, {7'b0, m_tx});
         chk("irq_empty", {7'b0, irq_empty}, {7'b0, (mq.size() == 0) && !m_busy});
         if (!bus_oe) chk("bus", bus, tb_rd_hit ? m_status() : 8'hFF);
      end
   end

   // ---------------------------------------------------------- stimulus
   task automatic bus_idle();
      mem_io = 1'b0; io_wr = 1'b0; io_rd = 1'b0; bus_oe = 1'b0; addr_bus = 8'h00;
   endtask

   task automatic drive_write(logic [7:0] a, logic [7:0] d);
      mem_io = 1'b1; io_wr = 1'b1; addr_bus = a; bus_drv = d; bus_oe = 1'b1;
   endtask

   task automatic io_write(logic [7:0] a, logic [7:0] d, int hold);
      @(negedge clk);
      drive_write(a, d);
      repeat (hold) @(negedge clk);
      bus_idle();
   endtask

   task automatic io_read(logic mio, logic [7:0] a, logic [7:0] exp, string name);
      @(negedge clk);
      mem_io = mio; io_rd = 1'b1; addr_bus = a;
      #2;
      chk(name, bus, exp);
      @(negedge clk);
      bus_idle();
   endtask

   task automatic wait_idle(int limit, string name);
      int n;
      n = 0;
      while (irq_empty !== 1'b1 && n < limit) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(name, {7'b0, irq_empty}, 8'd1);
   endtask

   logic [9:0] a5_bits;
   int         n;
   int         f0;
   logic       stayed_idle;

   initial begin : main
      a5_bits = 10'b1101001010;
      bus_idle();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      chk("reset_tx", {7'b0, tx}, 8'd1);
      chk("reset_irq", {7'b0, irq_empty}, 8'd1);
      chk("reset_bus", bus, 8'hFF);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Basic frame 8'hA5
      @(negedge clk);
      drive_write(PD, 8'hA5);
      @(posedge clk); #1;
      chk("push_edge_tx", {7'b0, tx}, 8'd1);
      chk("push_edge_irq", {7'b0, irq_empty}, 8'd0);
      @(negedge clk);
      bus_idle();
      @(posedge clk); #1;
      chk("pop_edge_tx", {7'b0, tx}, 8'd0);
      for (int j = 1; j <= 40; j++) begin
         @(posedge clk); #1;
         if (j % C == C / 2) chk($sformatf("a5_bit%0d", j / C), {7'b0, tx}, {7'b0, a5_bits[j/C]});
         if (j == 39) chk("a5_irq_busy", {7'b0, irq_empty}, 8'd0);
         if (j == 40) chk("a5_irq_done", {7'b0, irq_empty}, 8'd1);
      end

      // Strobe held 6 cycles pushes once
      repeat (3) @(negedge clk);
      f0 = m_frames;
      drive_write(PD, 8'h3C);
      for (int j = 0; j <= 41; j++) begin
         @(posedge clk); #1;
         if (j == 1)  chk("deb_start", {7'b0, tx}, 8'd0);
         if (j == 40) chk("deb_irq_busy", {7'b0, irq_empty}, 8'd0);
         if (j == 41) chk("deb_irq_done", {7'b0, irq_empty}, 8'd1);
         @(negedge clk);
         if (j == 5) bus_idle();
      end
      chk("deb_frames", 8'(m_frames - f0), 8'd1);

      // Fill and overflow
      repeat (2) @(negedge clk);
      f0 = m_frames;
      for (int i = 1; i <= 6; i++) io_write(PD, 8'(i), 1);
      io_read(1'b1, PS, 8'h0D, "status_ovf");
      io_read(1'b1, PS, 8'h05, "status_clr");

      // Push coinciding with the STOP-to-START pop while full
      n = 0;
      @(negedge clk);
      while (!(m_busy && m_t == FL - 1 && mq.size() == D) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("collision_window", {7'b0, n < 200}, 8'd1);
      drive_write(PD, 8'h77);
      @(negedge clk);
      bus_idle();
      io_read(1'b1, PS, 8'h05, "collision_status");
      wait_idle(600, "fill_drain");
      chk("fill_frames", 8'(m_frames - f0), 8'd6);

      // Bus discipline
      io_read(1'b0, PS, 8'hFF, "rd_memcycle");
      io_read(1'b1, 8'h02, 8'hFF, "rd_other_addr");
      io_write(PS, 8'h99, 1);
      repeat (4) @(negedge clk);
      chk("out_status_irq", {7'b0, irq_empty}, 8'd1);
      chk("out_status_tx", {7'b0, tx}, 8'd1);

      // Reset during DATA bit 3 with two bytes queued
      io_write(PD, 8'h11, 1);
      io_write(PD, 8'h22, 1);
      io_write(PD, 8'h33, 1);
      n = 0;
      while (!(m_busy && m_t / C == 4 && mq.size() == 2) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("midframe_window", {7'b0, n < 100}, 8'd1);
      chk("midframe_tx_low", {7'b0, tx}, 8'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_tx", {7'b0, tx}, 8'd1);
      chk("rst_mid_irq", {7'b0, irq_empty}, 8'd1);
      @(negedge clk);
      mem_io = 1'b1; io_rd = 1'b1; addr_bus = PS;
      #2;
      chk("rst_mid_status", bus, 8'h02);
      @(negedge clk);
      bus_idle();
      reset = 1'b0;
      stayed_idle = 1'b1;
      for (int j = 0; j < 120; j++) begin
         @(posedge clk); #1;
         if (tx !== 1'b1 || irq_empty !== 1'b1) stayed_idle = 1'b0;
      end
      chk("rst_no_frames", {7'b0, stayed_idle}, 8'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
